// File: rtl/fpu_round_arbiter_if.sv
// ----------------------------------------------------------------------------
// fpu_round_arbiter_if
//   Bundles the two requester channels, the result channel and the statistics
//   outputs of fpu_round_arbiter.
//   Modports:
//     slave  - the arbiter/round block (takes requests, drives results)
//     master - the surroundings (producers, result consumer)
//   Signals:
//     i_reqN_valid/o_reqN_ready   requester N handshake (N = 0 add/sub, 1 mul)
//     i_reqN_un_fl/exp/mant/tag   requester N operand, mant[3:0] are guard bits
//     o_valid/i_ready             result handshake
//     o_src/o_tag/o_exp/o_mant    result payload, o_mant has the hidden bit dropped
//     o_ov_fl/o_un_fl             result flags
//     o_gnt0_cnt/o_gnt1_cnt       grant statistics
//     o_ovf_cnt                   delivered-overflow statistics
// ----------------------------------------------------------------------------
interface fpu_round_arbiter_if #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
);
   logic             i_req0_valid;
   logic             o_req0_ready;
   logic             i_req0_un_fl;
   logic [7:0]       i_req0_exp;
   logic [27:0]      i_req0_mant;
   logic [TAG_W-1:0] i_req0_tag;

   logic             i_req1_valid;
   logic             o_req1_ready;
   logic             i_req1_un_fl;
   logic [7:0]       i_req1_exp;
   logic [27:0]      i_req1_mant;
   logic [TAG_W-1:0] i_req1_tag;

   logic             o_valid;
   logic             i_ready;
   logic             o_src;
   logic [TAG_W-1:0] o_tag;
   logic [7:0]       o_exp;
   logic [22:0]      o_mant;
   logic             o_ov_fl;
   logic             o_un_fl;

   logic [CNT_W-1:0] o_gnt0_cnt;
   logic [CNT_W-1:0] o_gnt1_cnt;
   logic [CNT_W-1:0] o_ovf_cnt;

   modport slave (
      input  i_req0_valid, i_req0_un_fl, i_req0_exp, i_req0_mant, i_req0_tag,
      output o_req0_ready,
      input  i_req1_valid, i_req1_un_fl, i_req1_exp, i_req1_mant, i_req1_tag,
      output o_req1_ready,
      output o_valid, o_src, o_tag, o_exp, o_mant, o_ov_fl, o_un_fl,
      input  i_ready,
      output o_gnt0_cnt, o_gnt1_cnt, o_ovf_cnt
   );

   modport master (
      output i_req0_valid, i_req0_un_fl, i_req0_exp, i_req0_mant, i_req0_tag,
      input  o_req0_ready,
      output i_req1_valid, i_req1_un_fl, i_req1_exp, i_req1_mant, i_req1_tag,
      input  o_req1_ready,
      input  o_valid, o_src, o_tag, o_exp, o_mant, o_ov_fl, o_un_fl,
      output i_ready,
      input  o_gnt0_cnt, o_gnt1_cnt, o_ovf_cnt
   );
endinterface

// File: rtl/fpu_round_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_round_arbiter
//   Shares one renormalize/round datapath between two FPU producers
//   (req0 = add/sub, req1 = mul). Stage S1 registers the round-robin winner,
//   stage S2 registers the truncate-plus-one rounded, renormalized result.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous reset, active-high
//     bus    fpu_round_arbiter_if.slave (requests, result, statistics)
//   Optional feature macro: FPU_RND_STATS_EN
//     defined   - saturating grant/overflow counters drive the *_cnt ports
//     undefined - no counter flops, *_cnt ports tied to zero
// ----------------------------------------------------------------------------
module fpu_round_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   fpu_round_arbiter_if.slave    bus
);

   // Guard bits are not stored: rounding always adds one at the LSB of the
   // kept field, so they never influence the result.
   typedef struct packed {
      logic             src;
      logic [TAG_W-1:0] tag;
      logic             un_fl;
      logic [7:0]       exp;
      logic [23:0]      mant;
   } s1_t;

   typedef struct packed {
      logic             src;
      logic [TAG_W-1:0] tag;
      logic [7:0]       exp;
      logic [22:0]      mant;
      logic             ov_fl;
      logic             un_fl;
   } s2_t;

   logic s1_valid, s2_valid;
   logic s1_en, s2_en;
   logic prio;
   logic gnt0, gnt1;
   s1_t  s1;
   s2_t  s2;
   s2_t  rnd;

   logic [24:0] sum;
   logic [7:0]  exp_inc;

   // A stage may advance when it is empty or its contents move on.
   assign s2_en = !s2_valid || bus.i_ready;
   assign s1_en = !s1_valid || s2_en;

   // ------------------------------------------------------------------------
   // Round-robin arbitration; grants only exist while S1 can accept.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (s1_en) begin
         if (bus.i_req0_valid && bus.i_req1_valid) begin
            gnt0 = !prio;
            gnt1 = prio;
         end else begin
            gnt0 = bus.i_req0_valid;
            gnt1 = bus.i_req1_valid;
         end
      end
   end

   assign bus.o_req0_ready = gnt0;
   assign bus.o_req1_ready = gnt1;

   // ------------------------------------------------------------------------
   // S1: winner register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1       <= '0;
         prio     <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= gnt0 || gnt1;
         if (gnt1) begin
            s1   <= '{src: 1'b1, tag: bus.i_req1_tag, un_fl: bus.i_req1_un_fl,
                      exp: bus.i_req1_exp, mant: bus.i_req1_mant[27:4]};
            prio <= 1'b0;
         end else if (gnt0) begin
            s1   <= '{src: 1'b0, tag: bus.i_req0_tag, un_fl: bus.i_req0_un_fl,
                      exp: bus.i_req0_exp, mant: bus.i_req0_mant[27:4]};
            prio <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Truncate-plus-one rounding with one-position renormalization on carry.
   // Exponent FF with carry wraps to 00 and reports no overflow; producers
   // never present that case.
   // ------------------------------------------------------------------------
   assign sum     = {1'b0, s1.mant} + 25'd1;
   assign exp_inc = s1.exp + 8'd1;

   always_comb begin
      rnd.src = s1.src;
      rnd.tag = s1.tag;
      if (sum[24]) begin
         rnd.exp   = exp_inc;
         rnd.mant  = sum[23:1];
         rnd.un_fl = 1'b0;
         rnd.ov_fl = &exp_inc;
      end else begin
         rnd.exp   = s1.exp;
         rnd.mant  = sum[22:0];
         rnd.un_fl = s1.un_fl;
         rnd.ov_fl = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // S2: result register; payload only reloads with a real op so the outputs
   // keep their last value through bubbles.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2       <= '0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2 <= rnd;
         end
      end
   end

   assign bus.o_valid = s2_valid;
   assign bus.o_src   = s2.src;
   assign bus.o_tag   = s2.tag;
   assign bus.o_exp   = s2.exp;
   assign bus.o_mant  = s2.mant;
   assign bus.o_ov_fl = s2.ov_fl;
   assign bus.o_un_fl = s2.un_fl;

   // ------------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------------
`ifdef FPU_RND_STATS_EN
   logic [CNT_W-1:0] gnt0_cnt, gnt1_cnt, ovf_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         gnt0_cnt <= '0;
         gnt1_cnt <= '0;
         ovf_cnt  <= '0;
      end else begin
         if (gnt0 && (gnt0_cnt != '1)) gnt0_cnt <= gnt0_cnt + 1'b1;
         if (gnt1 && (gnt1_cnt != '1)) gnt1_cnt <= gnt1_cnt + 1'b1;
         if (s2_valid && bus.i_ready && s2.ov_fl && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
      end
   end

   assign bus.o_gnt0_cnt = gnt0_cnt;
   assign bus.o_gnt1_cnt = gnt1_cnt;
   assign bus.o_ovf_cnt  = ovf_cnt;
`else
   assign bus.o_gnt0_cnt = {CNT_W{1'b0}};
   assign bus.o_gnt1_cnt = {CNT_W{1'b0}};
   assign bus.o_ovf_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fpu_round_arbiter
//   Directed bench for fpu_round_arbiter: reset, single ops, carry/overflow
//   boundaries, round-robin alternation, backpressure and mid-stream reset.
//   Inputs are driven 1 ns after the rising edge, outputs checked 1 ns later.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpu_round_arbiter;

   localparam int TAG_W = 4;
   localparam int CNT_W = 16;
`ifdef FPU_RND_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   fpu_round_arbiter_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   fpu_round_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic drive0(input logic v, input logic un, input logic [7:0] e,
                         input logic [27:0] m, input logic [TAG_W-1:0] t);
      bus.i_req0_valid = v;
      bus.i_req0_un_fl = un;
      bus.i_req0_exp   = e;
      bus.i_req0_mant  = m;
      bus.i_req0_tag   = t;
   endtask

   task automatic drive1(input logic v, input logic un, input logic [7:0] e,
                         input logic [27:0] m, input logic [TAG_W-1:0] t);
      bus.i_req1_valid = v;
      bus.i_req1_un_fl = un;
      bus.i_req1_exp   = e;
      bus.i_req1_mant  = m;
      bus.i_req1_tag   = t;
   endtask

   task automatic idle();
      drive0(1'b0, 1'b0, 8'h00, 28'h0, '0);
      drive1(1'b0, 1'b0, 8'h00, 28'h0, '0);
   endtask

   task automatic check_ready(input string name, input logic r0, input logic r1);
      check({name, ".ready0"}, 32'(bus.o_req0_ready), 32'(r0));
      check({name, ".ready1"}, 32'(bus.o_req1_ready), 32'(r1));
   endtask

   task automatic check_res(input string name, input logic src, input logic [TAG_W-1:0] tag,
                            input logic [7:0] e, input logic [22:0] m,
                            input logic ov, input logic un);
      check({name, ".valid"}, 32'(bus.o_valid), 32'd1);
      check({name, ".src"},   32'(bus.o_src),   32'(src));
      check({name, ".tag"},   32'(bus.o_tag),   32'(tag));
      check({name, ".exp"},   32'(bus.o_exp),   32'(e));
      check({name, ".mant"},  32'(bus.o_mant),  32'(m));
      check({name, ".ov"},    32'(bus.o_ov_fl), 32'(ov));
      check({name, ".un"},    32'(bus.o_un_fl), 32'(un));
   endtask

   task automatic check_cnt(input string name, input int g0, input int g1, input int ov);
      check({name, ".gnt0_cnt"}, 32'(bus.o_gnt0_cnt), 32'(g0));
      check({name, ".gnt1_cnt"}, 32'(bus.o_gnt1_cnt), 32'(g1));
      check({name, ".ovf_cnt"},  32'(bus.o_ovf_cnt),  32'(ov));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      bus.i_ready = 1'b1;
      idle();

      // ---- Reset state --------------------------------------------------
      tick();
      tick();
      check("rst.o_valid", 32'(bus.o_valid), 32'd0);
      check("rst.o_exp",   32'(bus.o_exp),   32'd0);
      check("rst.o_mant",  32'(bus.o_mant),  32'd0);
      check_cnt("rst", 0, 0, 0);
      drive0(1'b1, 1'b0, 8'h01, 28'h0, 4'd1);
      drive1(1'b1, 1'b0, 8'h02, 28'h0, 4'd2);
      #1;
      check_ready("rst.prio0", 1'b1, 1'b0);
      idle();
      rst = 1'b0;
      tick();

      // ---- Single op req0: 0x800000 + 1, no carry ----------------------
      drive0(1'b1, 1'b0, 8'h80, {24'h800000, 4'h0}, 4'd3);
      #1;
      check_ready("single.acc", 1'b1, 1'b0);
      tick();
      idle();
      check("single.lat1", 32'(bus.o_valid), 32'd0);
      tick();
      check_res("single", 1'b0, 4'd3, 8'h80, 23'h000001, 1'b0, 1'b0);
      tick();
      check("single.drain", 32'(bus.o_valid), 32'd0);

      // ---- Carry: all-ones mantissa, underflow cleared -----------------
      drive0(1'b1, 1'b1, 8'h7F, {24'hFFFFFF, 4'hA}, 4'd4);
      tick();
      idle();
      tick();
      check_res("carry", 1'b0, 4'd4, 8'h80, 23'h000000, 1'b0, 1'b0);
      tick();

      // ---- Carry into exponent FF: overflow ----------------------------
      drive0(1'b1, 1'b0, 8'hFE, {24'hFFFFFF, 4'h0}, 4'd7);
      tick();
      idle();
      tick();
      check_res("ovf", 1'b0, 4'd7, 8'hFF, 23'h000000, 1'b1, 1'b0);
      tick();
      check("ovf.drain", 32'(bus.o_valid), 32'd0);
      check_cnt("ovf", 3 * STATS, 0, STATS);

      // ---- Fresh reset, then both requesters for 6 cycles --------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_cnt("rst2", 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin
            drive0(1'b1, 1'b0, 8'(8'h40 + i), 28'h0, 4'(i));
            drive1(1'b1, 1'b0, 8'(8'h60 + i), 28'h0, 4'(8 + i));
            #1;
            check_ready($sformatf("rr.c%0d", i), (i % 2) == 0, (i % 2) == 1);
         end else begin
            idle();
         end
         tick();
         if (i >= 1 && i <= 6) begin
            check_res($sformatf("rr.r%0d", i - 1), ((i - 1) % 2) == 1,
                      ((i - 1) % 2 == 1) ? 4'(8 + i - 1) : 4'(i - 1),
                      ((i - 1) % 2 == 1) ? 8'(8'h60 + i - 1) : 8'(8'h40 + i - 1),
                      23'h000001, 1'b0, 1'b0);
         end else begin
            check($sformatf("rr.idle%0d", i), 32'(bus.o_valid), 32'd0);
         end
      end
      check_cnt("rr", 3 * STATS, 3 * STATS, 0);

      // ---- Backpressure: 5 cycles, only 2 ops accepted ------------------
      bus.i_ready = 1'b0;
      drive0(1'b1, 1'b0, 8'h10, {24'h000000, 4'hF}, 4'd5);
      drive1(1'b1, 1'b0, 8'h20, {24'h7FFFFF, 4'h0}, 4'd6);
      #1;
      check_ready("bp.c0", 1'b1, 1'b0);
      tick();
      check_ready("bp.c1", 1'b0, 1'b1);
      tick();
      for (int i = 2; i < 5; i++) begin
         check_ready($sformatf("bp.c%0d", i), 1'b0, 1'b0);
         check_res($sformatf("bp.hold%0d", i), 1'b0, 4'd5, 8'h10, 23'h000001, 1'b0, 1'b0);
         tick();
      end
      idle();
      bus.i_ready = 1'b1;
      #1;
      check("bp.rel.tag", 32'(bus.o_tag), 32'd5);
      tick();
      check_res("bp.second", 1'b1, 4'd6, 8'h20, 23'h000000, 1'b0, 1'b0);
      tick();
      check("bp.drain", 32'(bus.o_valid), 32'd0);

      // ---- req1 only with underflow, prio returns to req0 --------------
      drive1(1'b1, 1'b1, 8'h33, {24'h123456, 4'h0}, 4'd9);
      #1;
      check_ready("uf.acc", 1'b0, 1'b1);
      tick();
      drive0(1'b1, 1'b0, 8'h44, 28'h0, 4'd10);
      drive1(1'b1, 1'b0, 8'h55, 28'h0, 4'd11);
      #1;
      check_ready("uf.prio", 1'b1, 1'b0);
      tick();
      idle();
      check_res("uf", 1'b1, 4'd9, 8'h33, 23'h123457, 1'b0, 1'b1);

      // ---- Reset mid-stream: S1 holds req0 tag 10, S2 holds tag 9 ------
      drive0(1'b1, 1'b0, 8'h44, 28'h0, 4'd12);
      drive1(1'b1, 1'b0, 8'h55, 28'h0, 4'd13);
      #1;
      check_ready("mid.prio1", 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      check("mid.o_valid", 32'(bus.o_valid), 32'd0);
      check_ready("mid.rst", 1'b1, 1'b0);
      check_cnt("mid", 0, 0, 0);
      tick();
      rst = 1'b0;
      idle();
      tick();
      check("mid.discard", 32'(bus.o_valid), 32'd0);
      tick();
      check("mid.empty", 32'(bus.o_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
